uart_rx_deframer: RTL and testbench

//   Serial receive end of the 11-bit UART link: start, d0..d7 LSB-first, parity, stop.

---
 rtl/uart_rx_deframer.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - receive deframer for the 11-bit UART link
//
// Recovers one frame (start, d0..d7 LSB-first, parity, stop) from an idle-high
// serial line and presents the byte, the reassembled 11-bit packet and the
// parity/framing status. The input is passed through a 2-FF synchroniser, so
// the serial source may be asynchronous to clk.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_serial   serial line, idle high
//   rx_data     last received data byte
//   rx_packet   last frame: [0]=start [8:1]=d7..d0 [9]=parity [10]=stop
//   rx_valid    one-cycle pulse when a frame completes and outputs update
//   parity_err  parity mismatch on the last frame (held until next frame)
//   frame_err   stop bit sampled low on the last frame (held until next frame)
//   busy        high whenever the receiver is not idle
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_serial,
  output logic [7:0]  rx_data,
  output logic [10:0] rx_packet,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  // Terminal counts: mid start bit, and one full bit period thereafter.
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;

  // Synchroniser flops reset to 1 so an idle line does not look like a start.
  logic            sync1;
  logic            rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_packet  <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        // Re-check the start bit at its centre; a short low pulse is a glitch
        // and is dropped without touching any output.
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Sampling a full bit period after the start-bit centre keeps every
        // sample near the middle of its bit. Shifting in at the MSB leaves
        // the first (LSB) bit in shreg[0] after eight samples.
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // All results are published on the stop-bit sample edge. A low stop
        // bit means the line may be held in break, so wait for it to rise
        // instead of re-triggering on the same low level.
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            rx_data    <= shreg;
            rx_packet  <= {rx_s, par_bit, shreg, 1'b0};
            rx_valid   <= 1'b1;
            parity_err <= (^shreg) ^ par_bit ^ PARITY_ODD;
            frame_err  <= ~rx_s;
            if (rx_s) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        rx_serial;
  logic [7:0]  rx_data;
  logic [10:0] rx_packet;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;

  uart_rx_deframer #(
    .CLKS_PER_BIT(N),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_packet (rx_packet),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  data;
    logic [10:0] pkt;
    logic        perr;
    logic        ferr;
  } pulse_t;

  pulse_t pq[$];
  pulse_t mon_p;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      mon_p.cyc  = cyc;
      mon_p.data = rx_data;
      mon_p.pkt  = rx_packet;
      mon_p.perr = parity_err;
      mon_p.ferr = frame_err;
      pq.push_back(mon_p);
    end
  end

  typedef struct {
    logic [7:0]  d;
    logic        par;
    logic        stop;
    logic [10:0] exp_pkt;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int nbits);
    rx_serial = 1'b1;
    repeat (nbits * N) @(posedge clk);
    #1;
  endtask

  // Called at #1 after a rising edge; t0 is the next edge, where flop1 sees 0.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            output int t0);
    t0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic expect_pulse(input string tag, input logic [7:0] ed, input logic [10:0] ep,
                              input logic epe, input logic efe, input int t0);
    pulse_t p;
    check({tag, " pulse_count"}, pq.size(), 1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      check({tag, " latency"}, p.cyc - t0, 170);
      check({tag, " rx_data"}, p.data, ed);
      check({tag, " rx_packet"}, p.pkt, ep);
      check({tag, " parity_err"}, p.perr, epe);
      check({tag, " frame_err"}, p.ferr, efe);
    end
    pq.delete();
  endtask

  initial begin
    int     t0;
    int     t1;
    pulse_t pa;
    pulse_t pb;

    vecs[0] = '{d: 8'hA5, par: 1'b0, stop: 1'b1, exp_pkt: 11'h54A, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{d: 8'h01, par: 1'b0, stop: 1'b1, exp_pkt: 11'h402, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{d: 8'h03, par: 1'b0, stop: 1'b1, exp_pkt: 11'h406, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{d: 8'h80, par: 1'b1, stop: 1'b1, exp_pkt: 11'h700, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{d: 8'hC3, par: 1'b1, stop: 1'b1, exp_pkt: 11'h786, exp_perr: 1'b1, exp_ferr: 1'b0};

    rst_n     = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rx_data", rx_data, 0);
    check("reset rx_packet", rx_packet, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset parity_err", parity_err, 0);
    check("reset frame_err", frame_err, 0);
    check("reset busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Table of single frames with gaps
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, t0);
      idle(2);
      expect_pulse($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_pkt,
                   vecs[i].exp_perr, vecs[i].exp_ferr, t0);
    end

    // Stop bit low, line held low 40 clks, then release
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    rx_serial = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("break busy_held", busy, 1);
    expect_pulse("break", 8'h3C, 11'h078, 1'b0, 1'b1, t0);
    rx_serial = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("break busy_before_sync", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("break busy_after_sync", busy, 0);
    @(posedge clk);
    #1;
    idle(1);
    send_frame(8'h55, 1'b0, 1'b1, t0);
    idle(2);
    expect_pulse("after_break", 8'h55, 11'h4AA, 1'b0, 1'b0, t0);

    // 4-clock low glitch on an idle line
    t0 = cyc + 1;
    rx_serial = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    check("glitch busy_start", busy, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("glitch busy_last", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("glitch busy_dropped", busy, 0);
    @(posedge clk);
    #1;
    idle(3);
    check("glitch no_pulse", pq.size(), 0);
    pq.delete();

    // Back-to-back frames with zero idle bits
    send_frame(8'h00, 1'b0, 1'b1, t0);
    send_frame(8'hFF, 1'b0, 1'b1, t1);
    idle(2);
    check("b2b pulse_count", pq.size(), 2);
    if (pq.size() >= 2) begin
      pa = pq.pop_front();
      pb = pq.pop_front();
      check("b2b latency", pa.cyc - t0, 170);
      check("b2b spacing", pb.cyc - pa.cyc, 11 * N);
      check("b2b data0", pa.data, 8'h00);
      check("b2b pkt0", pa.pkt, 11'h400);
      check("b2b data1", pb.data, 8'hFF);
      check("b2b pkt1", pb.pkt, 11'h5FE);
      check("b2b perr1", pb.perr, 0);
      check("b2b ferr1", pb.ferr, 0);
    end
    pq.delete();

    // Reset in the middle of the data bits of 0x77
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("midreset busy_before", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset rx_data", rx_data, 0);
    check("midreset rx_packet", rx_packet, 0);
    check("midreset rx_valid", rx_valid, 0);
    check("midreset parity_err", parity_err, 0);
    check("midreset frame_err", frame_err, 0);
    check("midreset busy", busy, 0);
    @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (N) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    check("midreset no_pulse", pq.size(), 0);
    pq.delete();
    send_frame(8'h12, 1'b0, 1'b1, t0);
    idle(2);
    expect_pulse("post_reset", 8'h12, 11'h424, 1'b0, 1'b0, t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
